// File: rtl/clk_en_idle_ctrl_pkg.sv
// Shared encodings and widths for the idle-driven clock-enable controller.
package clk_en_idle_ctrl_pkg;

  typedef enum logic [1:0] {
    CEIC_ACTIVE    = 2'b00,
    CEIC_COUNTDOWN = 2'b01,
    CEIC_GATED     = 2'b10,
    CEIC_WAKE      = 2'b11
  } ceic_state_e;

  localparam int unsigned CEIC_EVT_CNT_W = 8;
  localparam logic [CEIC_EVT_CNT_W-1:0] CEIC_EVT_CNT_MAX = '1;

endpackage

// File: rtl/clk_gate_evt_cnt.sv
// Saturating count of gating events; a clear in the same cycle as an increment wins.
module clk_gate_evt_cnt
  import clk_en_idle_ctrl_pkg::*;
(
  input  logic                      forever_cpuclk,
  input  logic                      cpurst_b,
  input  logic                      inc,
  input  logic                      clr,
  output logic [CEIC_EVT_CNT_W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CEIC_EVT_CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clk_en_idle_ctrl.sv
// Drops the gated-clock enable after a run of idle cycles and stalls requests
// through a fixed wake window once activity returns.
module clk_en_idle_ctrl
  import clk_en_idle_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_THRESH = 8,
  parameter int unsigned WAKE_CYC    = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst_b,
  input  logic                      module_busy,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic                      cfg_gate_dis,
  output logic                      local_en,
  output logic                      clk_gated,
  input  logic                      gate_evt_clr,
  output logic [CEIC_EVT_CNT_W-1:0] gate_evt_cnt
);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_THRESH - 1);
  localparam logic [3:0]       WAKE_LAST = 4'(WAKE_CYC - 1);

  ceic_state_e      state, state_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic [3:0]       wake_cnt, wake_cnt_nxt;
  logic             wake_req;
  logic             gate_inc;

  // Gate-disable behaves like activity: it holds the clock on and wakes a gated module.
  assign wake_req = module_busy | req_vld | cfg_gate_dis;

  // NOTE: every variable gets a default before the case so no branch can infer a latch.
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    wake_cnt_nxt = wake_cnt;
    unique case (state)
      CEIC_ACTIVE: begin
        if (!wake_req) begin
          if (IDLE_THRESH == 1) begin
            state_nxt = CEIC_GATED;
          end else begin
            state_nxt    = CEIC_COUNTDOWN;
            idle_cnt_nxt = CNT_W'(1);
          end
        end
      end
      CEIC_COUNTDOWN: begin
        // Activity beats a coincident threshold match, so the clock stays on.
        if (wake_req) begin
          state_nxt    = CEIC_ACTIVE;
          idle_cnt_nxt = '0;
        end else if (idle_cnt == IDLE_LAST) begin
          state_nxt    = CEIC_GATED;
          idle_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
      CEIC_GATED: begin
        if (wake_req) begin
          state_nxt    = CEIC_WAKE;
          wake_cnt_nxt = '0;
        end
      end
      CEIC_WAKE: begin
        wake_cnt_nxt = wake_cnt + 1'b1;
        if (wake_cnt == WAKE_LAST) begin
          state_nxt = CEIC_ACTIVE;
        end
      end
      default: state_nxt = CEIC_ACTIVE;
    endcase
  end

  assign gate_inc = (state_nxt == CEIC_GATED) && (state != CEIC_GATED);

  // Outputs are flopped alongside the state so they are pure decodes of it.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state     <= CEIC_ACTIVE;
      idle_cnt  <= '0;
      wake_cnt  <= '0;
      local_en  <= 1'b1;
      req_rdy   <= 1'b1;
      clk_gated <= 1'b0;
    end else begin
      state     <= state_nxt;
      idle_cnt  <= idle_cnt_nxt;
      wake_cnt  <= wake_cnt_nxt;
      local_en  <= (state_nxt != CEIC_GATED);
      req_rdy   <= (state_nxt == CEIC_ACTIVE) || (state_nxt == CEIC_COUNTDOWN);
      clk_gated <= (state_nxt == CEIC_GATED);
    end
  end

  clk_gate_evt_cnt u_evt_cnt (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .inc            (gate_inc),
    .clr            (gate_evt_clr),
    .cnt            (gate_evt_cnt)
  );

endmodule

// File: tb/tb_clk_en_idle_ctrl.sv
// Scoreboard bench: stimulus pushes hand-derived per-cycle expectations, a
// negedge monitor pops and compares them against two builds of the controller.
module tb_clk_en_idle_ctrl;

  localparam logic [2:0] O_RUN   = 3'b110;  // {local_en, req_rdy, clk_gated}
  localparam logic [2:0] O_GATED = 3'b001;
  localparam logic [2:0] O_WAKE  = 3'b100;

  typedef struct {
    string      name;
    bit         which;
    logic [2:0] outs;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, busy, vld, cfg_dis, clr;
  logic       rdy0, le0, cg0;
  logic [7:0] cnt0;
  logic       busy1, vld1, cfg1, clr1;
  logic       rdy1, le1, cg1;
  logic [7:0] cnt1;

  exp_t       sb[$];
  exp_t       e;
  logic [2:0] act_o;
  logic [7:0] act_c;
  logic [7:0] exp_cnt = 8'd0;
  int         n_checks = 0;
  int         n_fail   = 0;

  clk_en_idle_ctrl #(.IDLE_THRESH(8), .WAKE_CYC(2), .CNT_W(8)) dut0 (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .module_busy    (busy),
    .req_vld        (vld),
    .req_rdy        (rdy0),
    .cfg_gate_dis   (cfg_dis),
    .local_en       (le0),
    .clk_gated      (cg0),
    .gate_evt_clr   (clr),
    .gate_evt_cnt   (cnt0)
  );

  clk_en_idle_ctrl #(.IDLE_THRESH(1), .WAKE_CYC(2), .CNT_W(8)) dut1 (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .module_busy    (busy1),
    .req_vld        (vld1),
    .req_rdy        (rdy1),
    .cfg_gate_dis   (cfg1),
    .local_en       (le1),
    .clk_gated      (cg1),
    .gate_evt_clr   (clr1),
    .gate_evt_cnt   (cnt1)
  );

  // Everything pushed since the last posedge belongs to the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e     = sb.pop_front();
      act_o = e.which ? {le1, rdy1, cg1} : {le0, rdy0, cg0};
      act_c = e.which ? cnt1 : cnt0;
      n_checks++;
      if ({act_o, act_c} !== {e.outs, e.cnt}) begin
        n_fail++;
        $display("FAIL %s (dut%0d): got en/rdy/gated=%b cnt=%0d, expected %b cnt=%0d",
                 e.name, e.which, act_o, act_c, e.outs, e.cnt);
      end
    end
  end

  task automatic push(input string nm, input bit which, input logic [2:0] o,
                      input logic [7:0] c);
    exp_t x;
    x.name  = nm;
    x.which = which;
    x.outs  = o;
    x.cnt   = c;
    sb.push_back(x);
  endtask

  task automatic tick(input string nm, input bit which, input logic [2:0] o,
                      input logic [7:0] c);
    @(posedge clk);
    #1;
    push(nm, which, o, c);
  endtask

  // Eight idle samples from ACTIVE: enable holds for seven, drops after the eighth.
  task automatic gate_run(input string nm, input bit clr_on_entry);
    busy = 1'b0;
    vld  = 1'b0;
    for (int i = 0; i < 7; i++) tick(nm, 1'b0, O_RUN, exp_cnt);
    clr     = clr_on_entry;
    exp_cnt = clr_on_entry ? 8'd0 : ((exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1);
    tick(nm, 1'b0, O_GATED, exp_cnt);
    clr = 1'b0;
  endtask

  // Wake from GATED: two stalled cycles, then the held request is accepted.
  task automatic wake_seq(input string nm, input bit use_cfg);
    if (use_cfg) cfg_dis = 1'b1;
    else vld = 1'b1;
    tick({nm, "_n1"}, 1'b0, O_WAKE, exp_cnt);
    tick({nm, "_n2"}, 1'b0, O_WAKE, exp_cnt);
    tick({nm, "_n3"}, 1'b0, O_RUN, exp_cnt);
    tick({nm, "_accept"}, 1'b0, O_RUN, exp_cnt);
    vld     = 1'b0;
    cfg_dis = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; busy = 1'b0; vld = 1'b0; cfg_dis = 1'b0; clr = 1'b0;
    busy1 = 1'b1; vld1 = 1'b0; cfg1 = 1'b0; clr1 = 1'b0;

    tick("reset", 1'b0, O_RUN, 8'd0);
    push("reset", 1'b1, O_RUN, 8'd0);
    rst_n = 1'b1;

    gate_run("idle8", 1'b0);
    tick("stay_gated", 1'b0, O_GATED, exp_cnt);
    tick("stay_gated", 1'b0, O_GATED, exp_cnt);

    wake_seq("wake_req", 1'b0);

    for (int i = 0; i < 5; i++) tick("broken_idle5", 1'b0, O_RUN, exp_cnt);
    busy = 1'b1;
    tick("broken_busy", 1'b0, O_RUN, exp_cnt);
    gate_run("restart_idle8", 1'b0);

    wake_seq("wake_cfg", 1'b1);
    cfg_dis = 1'b1;
    for (int i = 0; i < 100; i++) tick("cfg_dis_hold", 1'b0, O_RUN, exp_cnt);
    cfg_dis = 1'b0;

    gate_run("clr_on_entry", 1'b1);
    wake_seq("wake_after_clr", 1'b0);

    for (int i = 0; i < 260; i++) begin
      gate_run("sat_gate", 1'b0);
      wake_seq("sat_wake", 1'b0);
    end
    tick("sat_hold", 1'b0, O_RUN, 8'd255);

    busy = 1'b0;
    for (int i = 0; i < 4; i++) tick("pre_rst_idle", 1'b0, O_RUN, exp_cnt);
    rst_n   = 1'b0;
    exp_cnt = 8'd0;
    tick("rst_mid_count", 1'b0, O_RUN, exp_cnt);
    rst_n = 1'b1;
    gate_run("post_rst_idle8", 1'b0);
    vld = 1'b1;
    tick("rst_wake_entry", 1'b0, O_WAKE, exp_cnt);
    rst_n   = 1'b0;
    exp_cnt = 8'd0;
    tick("rst_in_wake", 1'b0, O_RUN, exp_cnt);
    rst_n = 1'b1;
    vld   = 1'b0;
    gate_run("post_wake_rst_idle8", 1'b0);

    busy1 = 1'b0;
    tick("thresh1_gate", 1'b1, O_GATED, 8'd1);
    busy1 = 1'b1;
    tick("thresh1_wake_n1", 1'b1, O_WAKE, 8'd1);
    tick("thresh1_wake_n2", 1'b1, O_WAKE, 8'd1);
    tick("thresh1_active", 1'b1, O_RUN, 8'd1);

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
